// File: rtl/icache_pkg.sv
// Shared types, AXI constants and region decode for the instruction fetch cache.
package icache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBurstAr,
    StBurstR,
    StWordAr,
    StWordR,
    StFill,
    StUncAr,
    StUncR
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

  // Device window that must never be cached, whatever the configured region says.
  localparam logic [31:0] UNC_WIN_LO = 32'h4000_0000;
  localparam logic [31:0] UNC_WIN_HI = 32'h7fff_ffff;

  function automatic logic is_cacheable(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] limit);
    return (addr >= base) && (addr < limit) && !((addr >= UNC_WIN_LO) && (addr <= UNC_WIN_HI));
  endfunction

  function automatic logic is_burst(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/icache_fetch_unit_array.sv
// Direct-mapped tag/valid/data storage: combinational read, single write, global valid clear.
module icache_array #(
  parameter int unsigned LINE_NUM = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned LINE_W   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINE_NUM-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [LINE_W-1:0]   data_q [LINE_NUM];

  // Valid bits: clear wins over a same-cycle install.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch_unit.sv
// Instruction fetch front-end: direct-mapped I-cache plus AXI4 read master with burst,
// word-by-word and uncached refill modes. Define ICACHE_PERF_EN to add hit/miss/uncached
// performance counters.
module icache_fetch_unit
  import icache_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned LINE_NUM    = 16,
  parameter logic [31:0] CACHE_BASE  = 32'h3000_0000,
  parameter logic [31:0] CACHE_LIMIT = 32'hc000_0000,
  parameter logic [31:0] BURST_BASE  = 32'ha000_0000,
  parameter logic [31:0] BURST_LIMIT = 32'hc000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        flush,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss,
  output logic [31:0] perf_unc_cycles
`endif
);

  localparam int unsigned W      = LINE_BYTES / 4;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(LINE_NUM);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WOFF_W = OFF_W - 2;
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(W - 1);

  fetch_state_e      state_q;
  logic [31:2]       addr_q;
  logic [WOFF_W-1:0] cnt_q;
  logic [LINE_W-1:0] line_buf_q;
  logic              err_q;
  logic              flush_seen_q;

  logic              accept;
  logic              cacheable;
  logic              burst;
  logic              hit;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic [WOFF_W-1:0] cnt_inc;

  assign arid      = 4'd0;
  assign arsize    = AXI_SIZE_WORD;
  assign rready    = 1'b1;
  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign cacheable = is_cacheable(req_addr, CACHE_BASE, CACHE_LIMIT);
  assign burst     = is_burst(req_addr, BURST_BASE, BURST_LIMIT);
  // A flush in the accept cycle invalidates the line before it could be used.
  assign hit       = cacheable && rd_valid && !flush && (rd_tag == req_addr[31 -: TAG_W]);
  assign cnt_inc   = cnt_q + WOFF_W'(1);
  // Poisoned (error) or flushed refills are delivered but never installed.
  assign wr_en     = (state_q == StFill) && !err_q && !flush_seen_q && !flush;

  icache_array #(
    .LINE_NUM (LINE_NUM),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .rd_idx   (req_addr[OFF_W +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (addr_q[OFF_W +: IDX_W]),
    .wr_tag   (addr_q[31 -: TAG_W]),
    .wr_data  (line_buf_q)
  );

  // Fetch FSM with registered response and AR channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cnt_q        <= '0;
      line_buf_q   <= '0;
      err_q        <= 1'b0;
      flush_seen_q <= 1'b0;
      resp_valid   <= 1'b0;
      resp_inst    <= '0;
      resp_err     <= 1'b0;
      arvalid      <= 1'b0;
      araddr       <= '0;
      arlen        <= '0;
      arburst      <= AXI_BURST_FIXED;
    end else begin
      resp_valid <= 1'b0;
      if (flush) flush_seen_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q       <= req_addr[31:2];
            cnt_q        <= '0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
            if (!cacheable) begin
              state_q <= StUncAr;
              arvalid <= 1'b1;
              araddr  <= req_addr;
              arlen   <= 8'd0;
              arburst <= AXI_BURST_FIXED;
            end else if (hit) begin
              resp_valid <= 1'b1;
              resp_inst  <= rd_data[{req_addr[OFF_W-1:2], 5'b0} +: 32];
              resp_err   <= 1'b0;
            end else if (burst) begin
              state_q <= StBurstAr;
              arvalid <= 1'b1;
              araddr  <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
              arlen   <= 8'(W - 1);
              arburst <= AXI_BURST_INCR;
            end else begin
              state_q <= StWordAr;
              arvalid <= 1'b1;
              araddr  <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
              arlen   <= 8'd0;
              arburst <= AXI_BURST_FIXED;
            end
          end
        end
        StBurstAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            state_q <= StBurstR;
          end
        end
        StBurstR: begin
          if (rvalid) begin
            // Shift in from the top so beat 0 ends up in the lowest word.
            line_buf_q <= {rdata, line_buf_q[LINE_W-1:32]};
            cnt_q      <= cnt_inc;
            if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (rlast) state_q <= StFill;
          end
        end
        StWordAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            state_q <= StWordR;
          end
        end
        StWordR: begin
          if (rvalid) begin
            line_buf_q[{cnt_q, 5'b0} +: 32] <= rdata;
            if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q <= StFill;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= StWordAr;
              arvalid <= 1'b1;
              araddr  <= {addr_q[31:OFF_W], cnt_inc, 2'b00};
            end
          end
        end
        StFill: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_inst  <= err_q ? 32'd0 : line_buf_q[{addr_q[OFF_W-1:2], 5'b0} +: 32];
          state_q    <= StIdle;
        end
        StUncAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            state_q <= StUncR;
          end
        end
        StUncR: begin
          if (rvalid) begin
            resp_valid <= 1'b1;
            resp_err   <= (rresp != AXI_RESP_OKAY);
            resp_inst  <= (rresp != AXI_RESP_OKAY) ? 32'd0 : rdata;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A burst must deliver exactly one line: rlast on beat W-1 and nowhere else.
  burst_rlast_a: assert property (@(posedge clk) disable iff (rst)
    ((state_q == StBurstR) && rvalid) |-> (rlast == (cnt_q == LAST_BEAT)));
`endif

`ifdef ICACHE_PERF_EN
  logic hit_evt;
  logic miss_evt;
  logic unc_evt;

  assign hit_evt  = accept && hit;
  assign miss_evt = (state_q == StFill);
  assign unc_evt  = (state_q == StUncAr) || (state_q == StUncR);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit        <= '0;
      perf_miss       <= '0;
      perf_unc_cycles <= '0;
    end else begin
      if (hit_evt && (perf_hit != '1)) perf_hit <= perf_hit + 32'd1;
      if (miss_evt && (perf_miss != '1)) perf_miss <= perf_miss + 32'd1;
      if (unc_evt && (perf_unc_cycles != '1)) perf_unc_cycles <= perf_unc_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench for icache_fetch_unit: AXI slave model, response scoreboard,
// one task per scenario.
module tb_icache_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        flush;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] exp_inst_q[$];
  logic        exp_err_q[$];
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [1:0]  ar_burst_log[$];

  int ar_delay     = 1;
  logic err_arm    = 1'b0;
  int err_beat     = 0;
  int beats_issued = 0;

  icache_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .flush      (flush),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arid       (arid),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'd2654435761) ^ 32'h5eed_1234;
  endfunction

  // AXI slave: drives on negedges; arready raised only while arvalid is high, so the
  // handshake lands on the following posedge.
  initial begin : axi_slave
    int wait_n;
    int beats_left;
    int beat_i;
    logic busy;
    logic b_err;
    logic [31:0] b_addr;
    logic [1:0]  b_burst;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
    wait_n = 0; beats_left = 0; beat_i = 0; busy = 0; b_err = 0; b_addr = 0; b_burst = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; rlast = 0; busy = 0; wait_n = 0; beats_left = 0;
      end else begin
        rvalid = 0; rlast = 0; rresp = 2'b00;
        if (arready) begin
          arready = 0;
        end else if (!busy && arvalid) begin
          if (wait_n >= ar_delay) begin
            arready = 1; wait_n = 0; busy = 1;
            ar_addr_log.push_back(araddr);
            ar_len_log.push_back(arlen);
            ar_burst_log.push_back(arburst);
            beats_left = int'(arlen) + 1; beat_i = 0;
            b_addr = araddr; b_burst = arburst; b_err = err_arm; err_arm = 0;
          end else begin
            wait_n++;
          end
        end
        if (busy && !arready && beats_left > 0 && $urandom_range(0, 3) != 0) begin
          rvalid = 1;
          rdata  = mem_word(b_burst == 2'b01 ? b_addr + 32'(4 * beat_i) : b_addr);
          rresp  = (b_err && beat_i == err_beat) ? 2'b10 : 2'b00;
          rlast  = (beats_left == 1);
          beat_i++; beats_left--; beats_issued++;
          if (beats_left == 0) busy = 0;
        end
      end
    end
  end

  // Scoreboard: every response is checked against the oldest expectation.
  initial begin : monitor
    logic [31:0] ei;
    logic ee;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        tests_run++;
        if (exp_inst_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_resp got inst=%h err=%b, required no response",
                   resp_inst, resp_err);
        end else begin
          ei = exp_inst_q.pop_front();
          ee = exp_err_q.pop_front();
          if (resp_inst !== ei || resp_err !== ee) begin
            failed++;
            $display("FAIL resp got inst=%h err=%b, required inst=%h err=%b",
                     resp_inst, resp_err, ei, ee);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic clear_log();
    ar_addr_log.delete(); ar_len_log.delete(); ar_burst_log.delete();
  endtask

  // Issue one fetch (optionally with flush in the accept cycle); lat = negedges from accept
  // to response, 1 meaning the response is registered by the accepting edge.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                          input logic fl, output int lat);
    int n;
    exp_inst_q.push_back(ei);
    exp_err_q.push_back(ee);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    req_valid = 1; req_addr = a; flush = fl;
    @(negedge clk);
    req_valid = 0; flush = 0;
    lat = 1;
    while (!resp_valid && lat < 400) begin @(negedge clk); lat++; end
    if (!resp_valid) begin
      tests_run++; failed++;
      $display("FAIL fetch_timeout addr=%h got no response, required one", a);
      void'(exp_inst_q.pop_back());
      void'(exp_err_q.pop_back());
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_inst !== 32'd0 ||
        resp_err !== 1'b0 || arvalid !== 1'b0) begin
      failed++;
      $display("FAIL reset_values got rdy=%b rv=%b inst=%h err=%b arv=%b, required 1 0 0 0 0",
               req_ready, resp_valid, resp_inst, resp_err, arvalid);
    end
    tests_run++;
    if (arid !== 4'd0 || arsize !== 3'b010 || rready !== 1'b1) begin
      failed++;
      $display("FAIL fixed_axi got arid=%h arsize=%b rready=%b, required 0 010 1",
               arid, arsize, rready);
    end
  endtask

  task automatic test_word_refill();
    int lat;
    clear_log();
    do_fetch(32'h8000_0004, mem_word(32'h8000_0004), 1'b0, 1'b0, lat);
    tests_run++;
    if (ar_addr_log.size() !== 4) begin
      failed++;
      $display("FAIL word_ar_count got %0d, required 4", ar_addr_log.size());
    end
    for (int i = 0; i < 4 && i < ar_addr_log.size(); i++) begin
      tests_run++;
      if (ar_addr_log[i] !== 32'h8000_0000 + 32'(4 * i) || ar_len_log[i] !== 8'd0 ||
          ar_burst_log[i] !== 2'b00) begin
        failed++;
        $display("FAIL word_ar[%0d] got addr=%h len=%0d burst=%b, required addr=%h len=0 burst=00",
                 i, ar_addr_log[i], ar_len_log[i], ar_burst_log[i], 32'h8000_0000 + 32'(4 * i));
      end
    end
    clear_log();
    do_fetch(32'h8000_0008, mem_word(32'h8000_0008), 1'b0, 1'b0, lat);
    tests_run++;
    if (lat !== 1 || ar_addr_log.size() !== 0) begin
      failed++;
      $display("FAIL word_hit got lat=%0d ars=%0d, required lat=1 ars=0", lat, ar_addr_log.size());
    end
  endtask

  task automatic test_burst_refill();
    int lat;
    clear_log();
    do_fetch(32'ha000_0010, mem_word(32'ha000_0010), 1'b0, 1'b0, lat);
    tests_run++;
    if (ar_addr_log.size() !== 1 || ar_addr_log[0] !== 32'ha000_0010 || ar_len_log[0] !== 8'd3 ||
        ar_burst_log[0] !== 2'b01) begin
      failed++;
      $display("FAIL burst_ar got n=%0d addr=%h len=%0d burst=%b, required n=1 a0000010 3 01",
               ar_addr_log.size(), ar_addr_log.size() > 0 ? ar_addr_log[0] : 32'hx,
               ar_len_log.size() > 0 ? ar_len_log[0] : 8'hx,
               ar_burst_log.size() > 0 ? ar_burst_log[0] : 2'bx);
    end
    clear_log();
    do_fetch(32'ha000_001c, mem_word(32'ha000_001c), 1'b0, 1'b0, lat);
    tests_run++;
    if (lat !== 1 || ar_addr_log.size() !== 0) begin
      failed++;
      $display("FAIL burst_hit got lat=%0d ars=%0d, required lat=1 ars=0", lat, ar_addr_log.size());
    end
  endtask

  task automatic test_uncached();
    int lat;
    logic [31:0] addrs [3];
    addrs[0] = 32'h1000_0000; addrs[1] = 32'h1000_0000; addrs[2] = 32'h4000_0010;
    for (int i = 0; i < 3; i++) begin
      clear_log();
      do_fetch(addrs[i], mem_word(addrs[i]), 1'b0, 1'b0, lat);
      tests_run++;
      if (ar_addr_log.size() !== 1 || ar_addr_log[0] !== addrs[i] || ar_len_log[0] !== 8'd0) begin
        failed++;
        $display("FAIL unc_ar[%0d] got n=%0d addr=%h, required n=1 addr=%h len=0",
                 i, ar_addr_log.size(), ar_addr_log.size() > 0 ? ar_addr_log[0] : 32'hx, addrs[i]);
      end
    end
  endtask

  task automatic test_error();
    int lat;
    int b0;
    clear_log();
    err_arm = 1'b1; err_beat = 2;
    b0 = beats_issued;
    do_fetch(32'ha000_0040, 32'd0, 1'b1, 1'b0, lat);
    tests_run++;
    if (beats_issued - b0 !== 4) begin
      failed++;
      $display("FAIL err_beats got %0d, required 4", beats_issued - b0);
    end
    clear_log();
    do_fetch(32'ha000_0044, mem_word(32'ha000_0044), 1'b0, 1'b0, lat);
    tests_run++;
    if (ar_addr_log.size() !== 1 || lat <= 1) begin
      failed++;
      $display("FAIL err_not_installed got ars=%0d lat=%0d, required ars=1 lat>1",
               ar_addr_log.size(), lat);
    end
  endtask

  task automatic test_flush();
    int lat;
    int lat2;
    clear_log();
    fork
      do_fetch(32'ha000_0080, mem_word(32'ha000_0080), 1'b0, 1'b0, lat);
      begin : pulse
        int n;
        n = 0;
        while (!rvalid && n < 200) begin @(negedge clk); n++; end
        flush = 1; @(negedge clk); flush = 0;
      end
    join
    clear_log();
    do_fetch(32'ha000_0080, mem_word(32'ha000_0080), 1'b0, 1'b0, lat);
    tests_run++;
    if (ar_addr_log.size() !== 1 || lat <= 1) begin
      failed++;
      $display("FAIL flush_refill got ars=%0d lat=%0d, required ars=1 lat>1",
               ar_addr_log.size(), lat);
    end
    clear_log();
    do_fetch(32'ha000_0084, mem_word(32'ha000_0084), 1'b0, 1'b0, lat);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    do_fetch(32'ha000_0084, mem_word(32'ha000_0084), 1'b0, 1'b0, lat2);
    tests_run++;
    if (lat !== 1 || lat2 <= 1 || ar_addr_log.size() !== 1) begin
      failed++;
      $display("FAIL flush_idle got hit_lat=%0d miss_lat=%0d ars=%0d, required 1 >1 1",
               lat, lat2, ar_addr_log.size());
    end
    clear_log();
    do_fetch(32'ha000_0088, mem_word(32'ha000_0088), 1'b0, 1'b1, lat);
    do_fetch(32'ha000_008c, mem_word(32'ha000_008c), 1'b0, 1'b0, lat2);
    tests_run++;
    if (lat <= 1 || lat2 !== 1 || ar_addr_log.size() !== 1) begin
      failed++;
      $display("FAIL flush_accept got miss_lat=%0d hit_lat=%0d ars=%0d, required >1 1 1",
               lat, lat2, ar_addr_log.size());
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    int n;
    do_fetch(32'h9000_0000, mem_word(32'h9000_0000), 1'b0, 1'b0, lat);
    ar_delay = 6;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h9000_0020;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!arvalid && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (arvalid !== 1'b1) begin
      failed++;
      $display("FAIL rst_setup got arvalid=%b, required 1", arvalid);
    end
    #2 rst = 1;
    #1;
    tests_run++;
    if (arvalid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid got arvalid=%b req_ready=%b resp_valid=%b, required 0 1 0",
               arvalid, req_ready, resp_valid);
    end
    @(negedge clk);
    rst = 0;
    ar_delay = 0;
    clear_log();
    do_fetch(32'h9000_0000, mem_word(32'h9000_0000), 1'b0, 1'b0, lat);
    tests_run++;
    if (ar_addr_log.size() !== 4 || lat <= 1) begin
      failed++;
      $display("FAIL rst_invalidates got ars=%0d lat=%0d, required ars=4 lat>1",
               ar_addr_log.size(), lat);
    end
  endtask

  initial begin : main
    rst = 1; req_valid = 0; req_addr = 0; flush = 0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_reset();
    test_word_refill();
    test_burst_refill();
    test_uncached();
    test_error();
    test_flush();
    test_reset_mid_refill();
    repeat (5) @(negedge clk);
    tests_run++;
    if (exp_inst_q.size() !== 0) begin
      failed++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", exp_inst_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
